cpu_seq_ctrl: RTL and testbench

// Multi-cycle control sequencer for the 16-bit core. Steps each instruction through FETCH, EXEC and optional MEM.

---
 rtl/cpu_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// Purpose    : multi-cycle FETCH/EXEC/MEM control sequencer for the 16-bit core.
// Latency    : ALU/jump/EXT 2 cycles, load/store 3 cycles, plus 1 per memory wait cycle.
// Backpressure: mem_req held until mem_ack; an ack timeout latches a sticky FAULT state.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_run                 execute enable, sampled only at instruction boundaries
//   i_dec_*               decoder class flags (valid from IR during EXEC/MEM)
//   i_mem_ack             completes the current memory request
//   o_mem_req/o_mem_we    memory request and store qualifier
//   o_addr_sel            address source: 0 = PC, 1 = ALU result
//   o_ir_load, o_pc_inc, o_pc_load, o_rf_wen, o_ext_load   single-cycle strobes
//   o_ext_active          EXT prefix applies to the current instruction's immediate
//   o_retire, o_busy, o_fault
//   o_retire_count        retired-instruction counter (only with CPU_SEQ_RETIRE_CNT_EN)
//
// Optional feature macro: CPU_SEQ_RETIRE_CNT_EN
module cpu_seq_ctrl #(
    parameter int REG_WIDTH   = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    input  logic                 i_dec_memldr,
    input  logic                 i_dec_memstr,
    input  logic                 i_dec_pcwrite,
    input  logic                 i_dec_ext,
    input  logic                 i_dec_wen1,
    input  logic                 i_mem_ack,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic                 o_addr_sel,
    output logic                 o_ir_load,
    output logic                 o_pc_inc,
    output logic                 o_pc_load,
    output logic                 o_rf_wen,
    output logic                 o_ext_load,
    output logic                 o_ext_active,
    output logic                 o_retire,
    output logic                 o_busy,
`ifdef CPU_SEQ_RETIRE_CNT_EN
    output logic [REG_WIDTH-1:0] o_retire_count,
`endif
    output logic                 o_fault
);

    // Reject configurations the timeout counter cannot represent.
    if (REG_WIDTH < 1 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_cfg
        $error("cpu_seq_ctrl: invalid REG_WIDTH/ACK_TIMEOUT");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // Counter value at which one more unacknowledged request cycle is fatal.
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_tmo_cnt;
    logic        r_ext_active;
    logic        w_mem_op;

    assign w_mem_op     = i_dec_memldr | i_dec_memstr;
    assign o_ext_active = r_ext_active;
    assign o_busy       = (r_state != S_IDLE);
    assign o_fault      = (r_state == S_FAULT);

    // Strobes are decoded straight from state, decoder flags and ack so that
    // zero-wait memory completes a request in the cycle it is raised.
    always_comb begin
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_addr_sel = 1'b0;
        o_ir_load  = 1'b0;
        o_pc_inc   = 1'b0;
        o_pc_load  = 1'b0;
        o_rf_wen   = 1'b0;
        o_ext_load = 1'b0;
        o_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                o_ir_load = i_mem_ack;
                o_pc_inc  = i_mem_ack;
            end
            S_EXEC: begin
                if (i_dec_ext) begin
                    o_ext_load = 1'b1;
                    o_retire   = 1'b1;
                end else if (!w_mem_op) begin
                    // A jump owns the write-back slot, so it never writes the RF.
                    o_rf_wen  = i_dec_wen1 & ~i_dec_pcwrite;
                    o_pc_load = i_dec_pcwrite;
                    o_retire  = 1'b1;
                end
            end
            S_MEM: begin
                o_mem_req  = 1'b1;
                o_addr_sel = 1'b1;
                o_mem_we   = i_dec_memstr;
                o_rf_wen   = i_mem_ack & i_dec_memldr;
                o_retire   = i_mem_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_tmo_cnt    <= 16'd0;
            r_ext_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (i_run) r_state <= S_FETCH;
                S_FETCH: if (i_mem_ack) r_state <= S_EXEC;
                S_EXEC: begin
                    if (!i_dec_ext && w_mem_op) r_state <= S_MEM;
                    else                        r_state <= i_run ? S_FETCH : S_IDLE;
                end
                S_MEM:   if (i_mem_ack) r_state <= i_run ? S_FETCH : S_IDLE;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase

            // Ack watchdog; overrides the state transition above on expiry.
            if (o_mem_req) begin
                if (i_mem_ack) begin
                    r_tmo_cnt <= 16'd0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    r_tmo_cnt <= 16'd0;
                    r_state   <= S_FAULT;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                end
            end

            // EXT arms the prefix; any other retirement consumes it.
            if (o_ext_load)    r_ext_active <= 1'b1;
            else if (o_retire) r_ext_active <= 1'b0;
        end
    end

`ifdef CPU_SEQ_RETIRE_CNT_EN
    logic [REG_WIDTH-1:0] r_retire_count;
    assign o_retire_count = r_retire_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)      r_retire_count <= '0;
        else if (o_retire) r_retire_count <= r_retire_count + REG_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
module tb_cpu_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, run = 1'b0, ack = 1'b0;
    logic d_ld = 1'b0, d_st = 1'b0, d_pw = 1'b0, d_ext = 1'b0, d_wen = 1'b0;
    logic mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic rf_wen, ext_load, ext_active, retire, busy, fault;
`ifdef CPU_SEQ_RETIRE_CNT_EN
    logic [15:0] rcnt;
`endif

    cpu_seq_ctrl #(.REG_WIDTH(16), .ACK_TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
        .i_dec_memldr(d_ld), .i_dec_memstr(d_st), .i_dec_pcwrite(d_pw),
        .i_dec_ext(d_ext), .i_dec_wen1(d_wen), .i_mem_ack(ack),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_addr_sel(addr_sel),
        .o_ir_load(ir_load), .o_pc_inc(pc_inc), .o_pc_load(pc_load),
        .o_rf_wen(rf_wen), .o_ext_load(ext_load), .o_ext_active(ext_active),
        .o_retire(retire), .o_busy(busy),
`ifdef CPU_SEQ_RETIRE_CNT_EN
        .o_retire_count(rcnt),
`endif
        .o_fault(fault)
    );

    typedef struct packed {
        logic mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
        logic rf_wen, ext_load, ext_active, retire, busy, fault;
    } out_t;

    // dec = {memldr, memstr, pcwrite, ext, wen1}
    typedef struct packed {
        logic       chk;
        logic       rst_n;
        logic       run;
        logic [4:0] dec;
        logic       ack;
    } in_t;

    localparam logic [4:0] F_ALU_W = 5'b00001;
    localparam logic [4:0] F_ALU   = 5'b00000;
    localparam logic [4:0] F_EXT   = 5'b00010;
    localparam logic [4:0] F_JMP   = 5'b00101;
    localparam logic [4:0] F_LD    = 5'b10001;
    localparam logic [4:0] F_ST    = 5'b01000;

    in_t         in_q[$];
    out_t        exp_q[$];
    logic [15:0] cnt_q[$];

    // Architectural model: prefix flag and retired-instruction count.
    logic m_ext = 1'b0;
    int   m_rcnt = 0;

    int n_chk = 0, n_err = 0;

    function automatic out_t base(input logic b);
        out_t o;
        o = '0;
        o.ext_active = m_ext;
        o.busy = b;
        return o;
    endfunction

    task automatic push(input logic c, input logic r, input logic rn,
                        input logic [4:0] dec, input logic a, input out_t e);
        in_t i;
        i.chk = c; i.rst_n = r; i.run = rn; i.dec = dec; i.ack = a;
        in_q.push_back(i);
        exp_q.push_back(e);
        cnt_q.push_back(16'(m_rcnt));
    endtask

    task automatic retired();
        m_rcnt = (m_rcnt + 1) % 65536;
    endtask

    task automatic idle(input logic rn, input logic a);
        push(1'b1, 1'b1, rn, 5'b10110, a, base(1'b0));
    endtask

    task automatic stall(input int n);
        out_t e;
        for (int i = 0; i < n; i++) begin
            e = base(1'b1);
            e.mem_req = 1'b1;
            push(1'b1, 1'b1, 1'b1, 5'b01010, 1'b0, e);
        end
    endtask

    task automatic rst_cycle(input out_t e);
        push(1'b1, 1'b0, 1'b1, 5'b00000, 1'b0, e);
        m_ext = 1'b0;
        m_rcnt = 0;
    endtask

    // One instruction: fetch with fw wait cycles, execute, and for loads/stores
    // a data access with mw wait cycles. run is dropped from EXEC onward when
    // the sequencer must stop after this instruction.
    task automatic instr(input logic [4:0] f, input int fw, input int mw, input logic run_after);
        out_t e;
        logic is_mem;
        is_mem = f[4] | f[3];
        for (int i = 0; i <= fw; i++) begin
            e = base(1'b1);
            e.mem_req = 1'b1;
            if (i == fw) begin
                e.ir_load = 1'b1;
                e.pc_inc = 1'b1;
            end
            push(1'b1, 1'b1, 1'b1, ~f, (i == fw), e);
        end
        e = base(1'b1);
        if (f[1]) begin
            e.ext_load = 1'b1;
            e.retire = 1'b1;
        end else if (!is_mem) begin
            e.rf_wen = f[0] & ~f[2];
            e.pc_load = f[2];
            e.retire = 1'b1;
        end
        push(1'b1, 1'b1, run_after, f, 1'b1, e);
        if (f[1]) begin
            m_ext = 1'b1;
            retired();
        end else if (!is_mem) begin
            m_ext = 1'b0;
            retired();
        end else begin
            for (int j = 0; j <= mw; j++) begin
                e = base(1'b1);
                e.mem_req = 1'b1;
                e.addr_sel = 1'b1;
                e.mem_we = f[3];
                if (j == mw) begin
                    e.rf_wen = f[4];
                    e.retire = 1'b1;
                end
                push(1'b1, 1'b1, run_after, f, (j == mw), e);
            end
            m_ext = 1'b0;
            retired();
        end
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        out_t e;
        out_t act;
        int n_ret = 0, n_irl = 0, n_flt = 0, first_req = -1, first_ret = -1;

        // Reset and quiet idle (ack while idle must be ignored).
        push(1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, base(1'b0));
        rst_cycle(base(1'b0));
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        // ALU ops back to back with zero-wait memory.
        idle(1'b1, 1'b0);
        instr(F_ALU_W, 0, 0, 1'b1);
        instr(F_ALU, 0, 0, 1'b1);
        // EXT prefix, its consumer, then EXT EXT and a load that clears it.
        instr(F_EXT, 0, 0, 1'b1);
        instr(F_ALU_W, 0, 0, 1'b1);
        instr(F_EXT, 0, 0, 1'b1);
        instr(F_EXT, 0, 0, 1'b1);
        instr(F_LD, 0, 1, 1'b1);
        // Jump with wen1 set.
        instr(F_JMP, 0, 0, 1'b1);
        // Load with a fetch wait and two data wait cycles, then a store.
        instr(F_LD, 1, 2, 1'b1);
        instr(F_ST, 0, 0, 1'b1);
        // Store with run dropped during the access: completes, then idle.
        instr(F_ST, 0, 1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        // EXT left pending in idle, then reset during a stalled fetch.
        idle(1'b1, 1'b0);
        instr(F_EXT, 0, 0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        stall(2);
        e = base(1'b1);
        e.mem_req = 1'b1;
        rst_cycle(e);
        idle(1'b1, 1'b1);
        // Three wait cycles stay below the timeout only if reset cleared the counter.
        instr(F_ALU_W, 3, 0, 1'b1);
        // Ack never arrives: fault after 4 request cycles, sticky until reset.
        stall(4);
        for (int i = 0; i < 3; i++) begin
            e = base(1'b1);
            e.fault = 1'b1;
            push(1'b1, 1'b1, 1'b1, 5'b11111, 1'b1, e);
        end
        rst_cycle(e);
        idle(1'b0, 1'b1);

        for (int k = 0; k < in_q.size(); k++) begin
            @(posedge clk);
            #1;
            rst_n = in_q[k].rst_n;
            run   = in_q[k].run;
            {d_ld, d_st, d_pw, d_ext, d_wen} = in_q[k].dec;
            ack   = in_q[k].ack;
            @(negedge clk);
            act = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
                   rf_wen, ext_load, ext_active, retire, busy, fault};
            if (in_q[k].chk) begin
                n_chk++;
                if (act !== exp_q[k]) begin
                    n_err++;
                    $display("FAIL outputs cycle %0d: got %b expected %b (req we asel irl pcinc pcld rfw extl exta ret busy flt)",
                             k, act, exp_q[k]);
                end
`ifdef CPU_SEQ_RETIRE_CNT_EN
                n_chk++;
                if (rcnt !== cnt_q[k]) begin
                    n_err++;
                    $display("FAIL retire_count cycle %0d: got %0d expected %0d", k, rcnt, cnt_q[k]);
                end
`endif
            end
            if (retire === 1'b1) n_ret++;
            if (ir_load === 1'b1) n_irl++;
            if (fault === 1'b1) n_flt++;
            if (mem_req === 1'b1 && first_req < 0) first_req = k;
            if (retire === 1'b1 && first_ret < 0) first_ret = k;
        end

        // Hand-counted totals over the directed program above.
        check_lit("first_mem_req_cycle", first_req, 5);
        check_lit("first_retire_cycle", first_ret, 6);
        check_lit("retire_pulses", n_ret, 13);
        check_lit("ir_load_pulses", n_irl, 13);
        check_lit("fault_cycles", n_flt, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
